// File: rtl/pin_auth_if.sv
// pin_auth_if: card/PIN handshake bundle between the terminal front end and
// the authentication controller.
//   i_card_in / i_card_code      : card presence level and code read from card
//   i_pin_in / i_pin_valid       : PIN attempt and its one-cycle strobe
//   i_done                       : downstream transaction finished
//   o_auth_ok, o_busy            : access granted / controller engaged
//   o_tempo, o_fail_cnt          : remaining attempt cycles / failed attempts
//   o_ejeta_tentativa/o_ejeta_tempo : one-cycle eject causes
//   o_locked                     : sticky lockout (only with CARD_LOCKOUT_EN)
// Modports: slave = controller side, master = terminal/driver side.
interface pin_auth_if #(parameter int PIN_W = 4);
  logic             i_card_in;
  logic [PIN_W-1:0] i_card_code;
  logic [PIN_W-1:0] i_pin_in;
  logic             i_pin_valid;
  logic             i_done;
  logic             o_auth_ok;
  logic [8:0]       o_tempo;
  logic [1:0]       o_fail_cnt;
  logic             o_ejeta_tentativa;
  logic             o_ejeta_tempo;
  logic             o_busy;
`ifdef CARD_LOCKOUT_EN
  logic             o_locked;
`endif

  modport slave (
`ifdef CARD_LOCKOUT_EN
    output o_locked,
`endif
    input  i_card_in, i_card_code, i_pin_in, i_pin_valid, i_done,
    output o_auth_ok, o_tempo, o_fail_cnt, o_ejeta_tentativa, o_ejeta_tempo, o_busy
  );

  modport master (
`ifdef CARD_LOCKOUT_EN
    input  o_locked,
`endif
    output i_card_in, i_card_code, i_pin_in, i_pin_valid, i_done,
    input  o_auth_ok, o_tempo, o_fail_cnt, o_ejeta_tentativa, o_ejeta_tempo, o_busy
  );
endinterface

// File: rtl/pin_auth_ctrl.sv
// pin_auth_ctrl: card/PIN authentication front end. Latches the card code on
// insertion, checks PIN attempts, counts failures, runs the per-attempt
// timeout and either grants access or ejects the card.
// Ports:
//   i_clk  : clock, all logic on rising edge
//   i_rst  : synchronous active-high reset
//   bus    : pin_auth_if.slave (see interface header for signal list)
// Optional: define CARD_LOCKOUT_EN to add the sticky o_locked output that
// refuses new cards after the tries have been exhausted, until reset.
module pin_auth_ctrl #(
  parameter int PIN_W       = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 400
) (
  input  logic       i_clk,
  input  logic       i_rst,
  pin_auth_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PIN, S_CHECK, S_GRANTED, S_EJECT
  } state_t;

  localparam logic [8:0] TMO   = 9'(TIMEOUT_CYC);
  localparam logic [2:0] TRIES = 3'(MAX_TRIES);

  state_t           r_state, w_nxt_state;
  logic [PIN_W-1:0] r_code, w_nxt_code;
  logic [PIN_W-1:0] r_pin, w_nxt_pin;
  logic [8:0]       r_tempo, w_nxt_tempo;
  logic [1:0]       r_fail, w_nxt_fail;
  logic             r_auth, r_busy, r_ej_try, r_ej_tmo;
  logic             w_nxt_ej_try, w_nxt_ej_tmo;
  logic             w_card_ok;
  logic [2:0]       w_fail_inc;
`ifdef CARD_LOCKOUT_EN
  logic             r_locked, w_nxt_locked;
`endif

  // widened so MAX_TRIES=3 compares without wrapping the 2-bit counter
  assign w_fail_inc = {1'b0, r_fail} + 3'd1;

`ifdef CARD_LOCKOUT_EN
  assign w_card_ok = bus.i_card_in & ~r_locked;
`else
  assign w_card_ok = bus.i_card_in;
`endif

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_code   = r_code;
    w_nxt_pin    = r_pin;
    w_nxt_tempo  = r_tempo;
    w_nxt_fail   = r_fail;
    w_nxt_ej_try = 1'b0;
    w_nxt_ej_tmo = 1'b0;
`ifdef CARD_LOCKOUT_EN
    w_nxt_locked = r_locked;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_card_ok) begin
          w_nxt_state = S_WAIT_PIN;
          w_nxt_code  = bus.i_card_code;
          w_nxt_tempo = TMO;
          w_nxt_fail  = 2'd0;
        end
      end
      S_WAIT_PIN: begin
        // card removal beats everything; a strobe beats the timeout
        if (!bus.i_card_in) begin
          w_nxt_state = S_IDLE;
          w_nxt_tempo = 9'd0;
        end else if (bus.i_pin_valid) begin
          w_nxt_state = S_CHECK;
          w_nxt_pin   = bus.i_pin_in;
        end else if (r_tempo == 9'd1) begin
          w_nxt_state  = S_EJECT;
          w_nxt_tempo  = 9'd0;
          w_nxt_ej_tmo = 1'b1;
        end else begin
          w_nxt_tempo = r_tempo - 9'd1;
        end
      end
      S_CHECK: begin
        if (!bus.i_card_in) begin
          w_nxt_state = S_IDLE;
          w_nxt_tempo = 9'd0;
        end else if (r_pin == r_code) begin
          w_nxt_state = S_GRANTED;
          w_nxt_tempo = 9'd0;
        end else begin
          w_nxt_fail = w_fail_inc[1:0];
          if (w_fail_inc == TRIES) begin
            // tempo is left as-is; it is meaningless once ejecting
            w_nxt_state  = S_EJECT;
            w_nxt_ej_try = 1'b1;
`ifdef CARD_LOCKOUT_EN
            w_nxt_locked = 1'b1;
`endif
          end else begin
            w_nxt_state = S_WAIT_PIN;
            w_nxt_tempo = TMO;
          end
        end
      end
      S_GRANTED: begin
        if (!bus.i_card_in) begin
          w_nxt_state = S_IDLE;
          w_nxt_tempo = 9'd0;
        end else if (bus.i_done) begin
          w_nxt_state = S_EJECT;
        end
      end
      S_EJECT: begin
        // fail_cnt intentionally held so the count survives into IDLE
        if (!bus.i_card_in) begin
          w_nxt_state = S_IDLE;
          w_nxt_tempo = 9'd0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_tempo = 9'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_code   <= '0;
      r_pin    <= '0;
      r_tempo  <= 9'd0;
      r_fail   <= 2'd0;
      r_auth   <= 1'b0;
      r_busy   <= 1'b0;
      r_ej_try <= 1'b0;
      r_ej_tmo <= 1'b0;
`ifdef CARD_LOCKOUT_EN
      r_locked <= 1'b0;
`endif
    end else begin
      r_state  <= w_nxt_state;
      r_code   <= w_nxt_code;
      r_pin    <= w_nxt_pin;
      r_tempo  <= w_nxt_tempo;
      r_fail   <= w_nxt_fail;
      // outputs registered from next state so they line up with r_state
      r_auth   <= (w_nxt_state == S_GRANTED);
      r_busy   <= (w_nxt_state != S_IDLE);
      r_ej_try <= w_nxt_ej_try;
      r_ej_tmo <= w_nxt_ej_tmo;
`ifdef CARD_LOCKOUT_EN
      r_locked <= w_nxt_locked;
`endif
    end
  end

  assign bus.o_auth_ok         = r_auth;
  assign bus.o_tempo           = r_tempo;
  assign bus.o_fail_cnt        = r_fail;
  assign bus.o_ejeta_tentativa = r_ej_try;
  assign bus.o_ejeta_tempo     = r_ej_tmo;
  assign bus.o_busy            = r_busy;
`ifdef CARD_LOCKOUT_EN
  assign bus.o_locked          = r_locked;
`endif

endmodule

// File: tb/tb_pin_auth_ctrl.sv
// Self-checking bench for pin_auth_ctrl: each scenario builds a stimulus
// table, pushes the expected output snapshot when the row is driven and pops
// it when the clocked result is sampled.
module tb_pin_auth_ctrl;
  localparam int TMO = 400;

  typedef struct packed {
    logic rst; logic card; logic [3:0] code; logic [3:0] pin; logic pv; logic done;
  } stim_t;

  typedef struct packed {
    logic auth; logic busy; logic [1:0] fail; logic [8:0] tempo; logic ej_try; logic ej_tmo;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   miss = 0;

  stim_t st[$];
  outs_t ex[$];
  outs_t sb[$];
  outs_t got, e;

  pin_auth_if #(.PIN_W(4)) bus ();

  pin_auth_ctrl #(.PIN_W(4), .MAX_TRIES(3), .TIMEOUT_CYC(TMO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t sm(logic r, logic c, logic [3:0] cd, logic [3:0] p, logic v, logic d);
    stim_t s;
    s.rst = r; s.card = c; s.code = cd; s.pin = p; s.pv = v; s.done = d;
    return s;
  endfunction

  function automatic outs_t xm(logic a, logic b, logic [1:0] f, int t, logic et, logic eo);
    outs_t o;
    o.auth = a; o.busy = b; o.fail = f; o.tempo = 9'(t); o.ej_try = et; o.ej_tmo = eo;
    return o;
  endfunction

  function automatic outs_t snap();
    outs_t o;
    o.auth = bus.o_auth_ok; o.busy = bus.o_busy; o.fail = bus.o_fail_cnt;
    o.tempo = bus.o_tempo; o.ej_try = bus.o_ejeta_tentativa; o.ej_tmo = bus.o_ejeta_tempo;
    return o;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; bus.i_card_in = s.card; bus.i_card_code = s.code;
    bus.i_pin_in = s.pin; bus.i_pin_valid = s.pv; bus.i_done = s.done;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    st = {}; ex = {};
    st.push_back(sm(1, 0, 4'h0, 4'h0, 0, 0)); ex.push_back(xm(0, 0, 0, 0, 0, 0));
    st.push_back(sm(0, 0, 4'h5, 4'h5, 1, 1)); ex.push_back(xm(0, 0, 0, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]); tick();
      got = snap(); e = sb.pop_front(); vecs++;
      if (got !== e) begin miss++; $display("FAIL reset[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_correct_pin();
    st = {}; ex = {};
    st.push_back(sm(1, 0, 4'h0, 4'h0, 0, 0)); ex.push_back(xm(0, 0, 0, 0,   0, 0));
    st.push_back(sm(0, 1, 4'hA, 4'h0, 0, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    st.push_back(sm(0, 1, 4'hA, 4'hA, 1, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    st.push_back(sm(0, 1, 4'hA, 4'hA, 0, 0)); ex.push_back(xm(1, 1, 0, 0,   0, 0));
    st.push_back(sm(0, 1, 4'hA, 4'hA, 1, 0)); ex.push_back(xm(1, 1, 0, 0,   0, 0));
    st.push_back(sm(0, 1, 4'hA, 4'hA, 0, 1)); ex.push_back(xm(0, 1, 0, 0,   0, 0));
    st.push_back(sm(0, 1, 4'hA, 4'hA, 0, 1)); ex.push_back(xm(0, 1, 0, 0,   0, 0));
    st.push_back(sm(0, 0, 4'hA, 4'hA, 0, 0)); ex.push_back(xm(0, 0, 0, 0,   0, 0));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]); tick();
      got = snap(); e = sb.pop_front(); vecs++;
      if (got !== e) begin miss++; $display("FAIL correct_pin[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_wrong_pins();
    st = {}; ex = {};
    st.push_back(sm(1, 0, 4'h0, 4'h0, 0, 0)); ex.push_back(xm(0, 0, 0, 0,   0, 0));
    st.push_back(sm(0, 1, 4'hA, 4'h0, 0, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    for (int k = 1; k <= 3; k++) begin
      st.push_back(sm(0, 1, 4'hA, 4'(k), 1, 0)); ex.push_back(xm(0, 1, 2'(k-1), TMO, 0, 0));
      st.push_back(sm(0, 1, 4'hA, 4'(k), 0, 0));
      ex.push_back(xm(0, 1, 2'(k), TMO, (k == 3), 0));
    end
    st.push_back(sm(0, 1, 4'hA, 4'h0, 1, 0)); ex.push_back(xm(0, 1, 3, TMO, 0, 0));
    st.push_back(sm(0, 0, 4'hA, 4'h0, 0, 0)); ex.push_back(xm(0, 0, 3, 0,   0, 0));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]); tick();
      got = snap(); e = sb.pop_front(); vecs++;
      if (got !== e) begin miss++; $display("FAIL wrong_pins[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_timeout();
    st = {}; ex = {};
    st.push_back(sm(1, 0, 4'h0, 4'h0, 0, 0)); ex.push_back(xm(0, 0, 0, 0,   0, 0));
    st.push_back(sm(0, 1, 4'h7, 4'h0, 0, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    for (int k = 1; k <= TMO + 1; k++) begin
      st.push_back(sm(0, 1, 4'h7, 4'h0, 0, 0));
      if (k < TMO) ex.push_back(xm(0, 1, 0, TMO - k, 0, 0));
      else         ex.push_back(xm(0, 1, 0, 0, 0, (k == TMO)));
    end
    st.push_back(sm(0, 0, 4'h7, 4'h0, 0, 0)); ex.push_back(xm(0, 0, 0, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]); tick();
      got = snap(); e = sb.pop_front(); vecs++;
      if (got !== e) begin miss++; $display("FAIL timeout[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_boundary();
    st = {}; ex = {};
    st.push_back(sm(1, 0, 4'h0, 4'h0, 0, 0)); ex.push_back(xm(0, 0, 0, 0,   0, 0));
    st.push_back(sm(0, 1, 4'h3, 4'h0, 0, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    for (int k = 1; k < TMO; k++) begin
      st.push_back(sm(0, 1, 4'h3, 4'h0, 0, 0)); ex.push_back(xm(0, 1, 0, TMO - k, 0, 0));
    end
    // tempo is 1 here: the strobe must win over the timeout
    st.push_back(sm(0, 1, 4'h3, 4'h3, 1, 0)); ex.push_back(xm(0, 1, 0, 1, 0, 0));
    st.push_back(sm(0, 1, 4'h3, 4'h3, 0, 0)); ex.push_back(xm(1, 1, 0, 0, 0, 0));
    st.push_back(sm(0, 1, 4'h3, 4'h3, 0, 0)); ex.push_back(xm(1, 1, 0, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]); tick();
      got = snap(); e = sb.pop_front(); vecs++;
      if (got !== e) begin miss++; $display("FAIL boundary[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_card_pull();
    st = {}; ex = {};
    st.push_back(sm(1, 0, 4'h0, 4'h0, 0, 0)); ex.push_back(xm(0, 0, 0, 0,   0, 0));
    st.push_back(sm(0, 1, 4'h9, 4'h0, 0, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    st.push_back(sm(0, 1, 4'h9, 4'h9, 1, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    st.push_back(sm(0, 1, 4'h9, 4'h9, 0, 0)); ex.push_back(xm(1, 1, 0, 0,   0, 0));
    st.push_back(sm(0, 0, 4'h9, 4'h9, 0, 0)); ex.push_back(xm(0, 0, 0, 0,   0, 0));
    // pull in WAIT_PIN after one miss: fail_cnt kept, no pulse
    st.push_back(sm(0, 1, 4'h9, 4'h0, 0, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    st.push_back(sm(0, 1, 4'h9, 4'h1, 1, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    st.push_back(sm(0, 1, 4'h9, 4'h1, 0, 0)); ex.push_back(xm(0, 1, 1, TMO, 0, 0));
    st.push_back(sm(0, 0, 4'h9, 4'h1, 0, 0)); ex.push_back(xm(0, 0, 1, 0,   0, 0));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]); tick();
      got = snap(); e = sb.pop_front(); vecs++;
      if (got !== e) begin miss++; $display("FAIL card_pull[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_rst_in_check();
    st = {}; ex = {};
    st.push_back(sm(1, 0, 4'h0, 4'h0, 0, 0)); ex.push_back(xm(0, 0, 0, 0,   0, 0));
    st.push_back(sm(0, 1, 4'hC, 4'h0, 0, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    st.push_back(sm(0, 1, 4'hC, 4'h5, 1, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    st.push_back(sm(1, 1, 4'hC, 4'h5, 0, 0)); ex.push_back(xm(0, 0, 0, 0,   0, 0));
    st.push_back(sm(0, 1, 4'h6, 4'h5, 0, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    st.push_back(sm(0, 1, 4'h6, 4'h6, 1, 0)); ex.push_back(xm(0, 1, 0, TMO, 0, 0));
    st.push_back(sm(0, 1, 4'h6, 4'h6, 0, 0)); ex.push_back(xm(1, 1, 0, 0,   0, 0));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]); tick();
      got = snap(); e = sb.pop_front(); vecs++;
      if (got !== e) begin miss++; $display("FAIL rst_check[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

`ifdef CARD_LOCKOUT_EN
  task automatic test_lockout();
    logic [1:0] lq[$];
    logic [1:0] lg, le;
    st = {};
    st.push_back(sm(1, 0, 4'h0, 4'h0, 0, 0)); lq.push_back(2'b00);
    st.push_back(sm(0, 1, 4'hA, 4'h0, 0, 0)); lq.push_back(2'b01);
    for (int k = 1; k <= 3; k++) begin
      st.push_back(sm(0, 1, 4'hA, 4'(k), 1, 0)); lq.push_back(2'b01);
      st.push_back(sm(0, 1, 4'hA, 4'(k), 0, 0)); lq.push_back((k == 3) ? 2'b11 : 2'b01);
    end
    st.push_back(sm(0, 0, 4'hA, 4'h0, 0, 0)); lq.push_back(2'b10);
    for (int k = 0; k < 3; k++) begin
      st.push_back(sm(0, 1, 4'hA, 4'h0, 0, 0)); lq.push_back(2'b10);
    end
    st.push_back(sm(1, 1, 4'hA, 4'h0, 0, 0)); lq.push_back(2'b00);
    st.push_back(sm(0, 1, 4'hA, 4'h0, 0, 0)); lq.push_back(2'b01);
    foreach (st[i]) begin
      drive(st[i]); tick();
      lg = {bus.o_locked, bus.o_busy}; le = lq.pop_front(); vecs++;
      if (lg !== le) begin miss++; $display("FAIL lockout[%0d] locked,busy got=%b exp=%b", i, lg, le); end
    end
  endtask
`endif

  initial begin
    drive(sm(1, 0, 4'h0, 4'h0, 0, 0));
    test_reset();
    test_correct_pin();
    test_wrong_pins();
    test_timeout();
    test_boundary();
    test_card_pull();
    test_rst_in_check();
`ifdef CARD_LOCKOUT_EN
    test_lockout();
`endif
    if (sb.size() != 0) begin
      miss++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
